// File: rtl/instruction_fetch.sv
// Fetches opcode plus 0-2 operand bytes from a registered ROM and hands the bundle to the decoder.
// Optional halt opcode (0xF4) support is compiled in when IFETCH_HALT_EN is defined.
module instruction_fetch #(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic [7:0]        instr_opnd_a,
  output logic [7:0]        instr_opnd_b,
  output logic [1:0]        instr_nops,
  output logic              pc_load,
  output logic [7:0]        opcode,
  input  logic              flush,
  output logic              halted
);

`ifdef IFETCH_HALT_EN
  typedef enum logic [2:0] {
    ISSUE_OP, WAIT_OP, WAIT_A, WAIT_B, DELIVER, ADVANCE, HALTED
  } state_t;
`else
  typedef enum logic [2:0] {
    ISSUE_OP, WAIT_OP, WAIT_A, WAIT_B, DELIVER, ADVANCE
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  opnd_a_q, opnd_a_d;
  logic [7:0]  opnd_b_q, opnd_b_d;
  logic [1:0]  nops_q, nops_d;
  logic        rd_c;
  logic [ADDR_W-1:0] addr_c;
  logic        valid_c;
  logic        load_c;
  logic        halted_c;
  logic [1:0]  dec_nops;

  function automatic logic [1:0] decode_nops(input logic [7:0] op);
`ifdef IFETCH_HALT_EN
    if (op == 8'hF4) return 2'd0;
`endif
    if (!op[7])     return 2'd1;
    else if (!op[6]) return op[1] ? 2'd0 : 2'd1;
    else            return 2'd2;
  endfunction

  assign dec_nops = decode_nops(mem_data);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ISSUE_OP;
      opcode_q <= '0;
      opnd_a_q <= '0;
      opnd_b_q <= '0;
      nops_q   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      opnd_a_q <= opnd_a_d;
      opnd_b_q <= opnd_b_d;
      nops_q   <= nops_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    opnd_a_d = opnd_a_q;
    opnd_b_d = opnd_b_q;
    nops_d   = nops_q;
    rd_c     = 1'b0;
    addr_c   = '0;
    valid_c  = 1'b0;
    load_c   = 1'b0;
    halted_c = 1'b0;
    case (state_q)
      ISSUE_OP: begin
        rd_c    = 1'b1;
        addr_c  = pc;
        state_d = WAIT_OP;
      end
      WAIT_OP: begin
        opcode_d = mem_data;
        nops_d   = dec_nops;
        opnd_a_d = '0;
        opnd_b_d = '0;
        if (dec_nops != 2'd0) begin
          rd_c    = 1'b1;
          addr_c  = pc + ADDR_W'(1);
          state_d = WAIT_A;
        end else begin
          state_d = DELIVER;
        end
      end
      WAIT_A: begin
        opnd_a_d = mem_data;
        if (nops_q == 2'd2) begin
          rd_c    = 1'b1;
          addr_c  = pc + ADDR_W'(2);
          state_d = WAIT_B;
        end else begin
          state_d = DELIVER;
        end
      end
      WAIT_B: begin
        opnd_b_d = mem_data;
        state_d  = DELIVER;
      end
      DELIVER: begin
        valid_c = 1'b1;
        if (instr_ready) begin
`ifdef IFETCH_HALT_EN
          state_d = (opcode_q == 8'hF4) ? HALTED : ADVANCE;
`else
          state_d = ADVANCE;
`endif
        end
      end
      ADVANCE: begin
        load_c  = 1'b1;
        state_d = ISSUE_OP;
      end
`ifdef IFETCH_HALT_EN
      HALTED: halted_c = 1'b1;
`endif
      default: state_d = ISSUE_OP;
    endcase
    // A flushed operand read would be discarded, so suppress it; an ADVANCE pulse still completes.
    if (flush) begin
      state_d = ISSUE_OP;
      valid_c = 1'b0;
      if (state_q != ISSUE_OP) rd_c = 1'b0;
    end
  end

  assign mem_rd       = reset & rd_c;
  assign mem_addr     = reset ? addr_c : '0;
  assign instr_valid  = valid_c;
  assign instr_opcode = opcode_q;
  assign instr_opnd_a = opnd_a_q;
  assign instr_opnd_b = opnd_b_q;
  assign instr_nops   = nops_q;
  assign pc_load      = load_c;
  assign opcode       = load_c ? opcode_q : 8'h00;
  assign halted       = halted_c;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed + randomized bench for instruction_fetch with a ROM and program_counter model.
module tb_instruction_fetch;
  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] pc;
  logic       mem_rd;
  logic [5:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode, instr_opnd_a, instr_opnd_b;
  logic [1:0] instr_nops;
  logic       pc_load;
  logic [7:0] opcode;
  logic       flush;
  logic       halted;

  logic [7:0] rom [64];
  int checks = 0;
  int errors = 0;

  instruction_fetch #(.ADDR_W(6)) dut (
    .clock(clock), .reset(reset), .pc(pc), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_opnd_a(instr_opnd_a), .instr_opnd_b(instr_opnd_b),
    .instr_nops(instr_nops), .pc_load(pc_load), .opcode(opcode), .flush(flush),
    .halted(halted)
  );

  always #5 clock = ~clock;

  // Registered ROM: data appears the cycle after the read strobe.
  always @(posedge clock) if (mem_rd) mem_data <= rom[mem_addr];

  function automatic int nops_of(input logic [7:0] op);
`ifdef IFETCH_HALT_EN
    if (op == 8'hF4) return 0;
`endif
    if (op < 8'h80) return 1;
    if (op < 8'hC0) return ((op & 8'h02) != 0) ? 0 : 1;
    return 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting at the ISSUE_OP cycle; stall = cycles with ready low in DELIVER.
  task automatic run_instr(input int stall, input bit at_issue);
    logic [7:0] op, a, b;
    logic [5:0] addrs[$];
    int n, cyc;
    logic [5:0] p;
    if (!at_issue) @(negedge clock);
    p  = pc;
    op = rom[p];
    n  = nops_of(op);
    a  = (n > 0) ? rom[6'(p + 6'd1)] : 8'h00;
    b  = (n == 2) ? rom[6'(p + 6'd2)] : 8'h00;
    if (mem_rd) addrs.push_back(mem_addr);
    chk("issue_rd", {31'd0, mem_rd}, 1);
    cyc = 0;
    while (cyc < 8) begin
      @(negedge clock);
      cyc++;
      if (mem_rd) addrs.push_back(mem_addr);
      if (pc_load) chk("early_pc_load", 1, 0);
      if (instr_valid) break;
    end
    chk("valid_latency", cyc, 2 + n);
    chk("addr_count", addrs.size(), n + 1);
    for (int k = 0; k < addrs.size() && k <= n; k++)
      chk("addr_seq", {26'd0, addrs[k]}, {26'd0, 6'(p + 6'(k))});
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clock);
      chk("bundle", {instr_valid, instr_opcode, instr_nops, instr_opnd_a, instr_opnd_b},
          {1'b1, op, 2'(n), a, b});
      chk("deliver_no_load", {pc_load, opcode}, 0);
      chk("halted_low", {31'd0, halted}, 0);
      instr_ready = (s == stall);
    end
    @(negedge clock);
    chk("advance", {pc_load, opcode, instr_valid}, {1'b1, op, 1'b0});
    instr_ready = 1'b0;
    pc = 6'(p + 6'(1 + n));
    $display("instr pc=%0d op=%02h nops=%0d a=%02h b=%02h stall=%0d next_pc=%0d",
             p, op, n, a, b, stall, pc);
  endtask

  task automatic do_reset(input logic [5:0] start_pc);
    reset = 1'b0;
    pc    = start_pc;
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    instr_ready = 1'b0;
    flush = 1'b0;
    pc = 6'd0;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rom[i] = 8'($urandom);
`ifdef IFETCH_HALT_EN
      if (rom[i] == 8'hF4) rom[i] = 8'hF5;
`endif
    end
    rom[0] = 8'h83; rom[1] = 8'h78; rom[2] = 8'h11;
    rom[3] = 8'hFF; rom[4] = 8'h22; rom[5] = 8'h33;
    rom[62] = 8'hFF; rom[63] = 8'hAA;

    // Reset held three cycles: every output zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("reset_outputs", {mem_rd, mem_addr, instr_valid, instr_opcode, instr_nops, pc_load,
                            opcode, halted}, 0);
      chk("reset_operands", {instr_opnd_a, instr_opnd_b}, 0);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("first_addr", {26'd0, mem_addr}, 0);
    run_instr(0, 1'b1);
    run_instr(0, 1'b0);
    run_instr(0, 1'b0);
    chk("pc_after_three", {26'd0, pc}, 6);
    run_instr(5, 1'b0);

    for (int i = 0; i < 20; i++) run_instr(int'($urandom_range(0, 2)), 1'b0);

    // Address wrap: 62, 63, 0.
    do_reset(6'd62);
    run_instr(0, 1'b0);
    chk("pc_wrapped", {26'd0, pc}, 1);

    // Asynchronous reset mid-fetch.
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    pc = 6'd62;
    #1;
    chk("async_reset", {mem_rd, instr_valid, pc_load, instr_opcode}, 0);
    @(posedge clock);
    #1 reset = 1'b1;

    // Flush in WAIT_A.
    @(negedge clock);
    chk("flush_issue", {mem_rd, mem_addr}, {1'b1, 6'd62});
    @(negedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    chk("after_flush_a", {mem_rd, mem_addr, pc_load, instr_valid}, {1'b1, 6'd62, 1'b0, 1'b0});
    run_instr(0, 1'b1);

    // Flush and ready together in DELIVER: flush wins.
    @(negedge clock);
    while (!instr_valid) @(negedge clock);
    instr_ready = 1'b1;
    flush = 1'b1;
    @(posedge clock);
    #1 begin flush = 1'b0; instr_ready = 1'b0; end
    @(negedge clock);
    chk("flush_beats_ready", {pc_load, mem_rd, mem_addr}, {1'b0, 1'b1, pc});
    run_instr(1, 1'b1);

`ifdef IFETCH_HALT_EN
    rom[40] = 8'hF4;
    do_reset(6'd40);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    chk("halt_bundle", {instr_valid, instr_opcode, instr_nops}, {1'b1, 8'hF4, 2'd0});
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      instr_ready = 1'b0;
      chk("halted_state", {halted, mem_rd, pc_load}, {1'b1, 1'b0, 1'b0});
    end
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    @(negedge clock);
    chk("halt_exit", {halted, mem_rd, mem_addr}, {1'b0, 1'b1, 6'd40});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch unit that sits between program memory and `program_counter`. It reads the opcode at the current `pc` and decodes the operand count. It then reads 0, 1 or 2 operand bytes and presents the complete instruction to the decoder through a valid/ready handshake. When the decoder accepts the instruction, the unit pulses `pc_load` with the opcode so `program_counter` advances by the instruction length.

## Interface
- `ADDR_W`, 6, program address width; must equal the `pc` width.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc`  in  ADDR_W  current address from `program_counter`.
- `mem_rd`  out  1  program memory read strobe.
- `mem_addr`  out  ADDR_W  program memory address.
- `mem_data`  in  8  read data, valid the cycle after `mem_rd`=1 (registered ROM).
- `instr_valid`  out  1  instruction bundle valid.
- `instr_ready`  in  1  decoder accepts the bundle.
- `instr_opcode`  out  8  fetched opcode.
- `instr_opnd_a`  out  8  first operand; 0 if unused.
- `instr_opnd_b`  out  8  second operand; 0 if unused.
- `instr_nops`  out  2  operand count, 0 to 2.
- `pc_load`  out  1  one-cycle advance pulse to `program_counter`.
- `opcode`  out  8  opcode presented to `program_counter`; valid while `pc_load`=1, 0 otherwise.
- `flush`  in  1  abandon the current fetch; synchronous.
- `halted`  out  1  halt status; tied 0 unless `IFETCH_HALT_EN` is defined.

## Operation
- Operand-count decode:
  - opcode[7]=0: 1 operand.
  - opcode[7:6]=10 with opcode[1]=0: 1 operand.
  - opcode[7:6]=10 with opcode[1]=1: 0 operands.
  - opcode[7:6]=11: 2 operands.
- Examples: 0x78→1, 0x83→0, 0x81→1, 0xFF→2.
- FSM states: ISSUE_OP, WAIT_OP, WAIT_A, WAIT_B, DELIVER, ADVANCE (plus HALTED under the macro).
  - ISSUE_OP: `mem_rd`=1, `mem_addr`=`pc`. Next state WAIT_OP.
  - WAIT_OP: capture `mem_data` as the opcode and latch `instr_nops`. If nops>0, `mem_rd`=1 with `mem_addr`=`pc`+1 and go to WAIT_A; else go to DELIVER.
  - WAIT_A: capture `instr_opnd_a`. If nops=2, `mem_rd`=1 with `mem_addr`=`pc`+2 and go to WAIT_B; else go to DELIVER.
  - WAIT_B: capture `instr_opnd_b`. Next state DELIVER.
  - DELIVER: `instr_valid`=1. When `instr_ready`=1, go to ADVANCE; otherwise hold.
  - ADVANCE: `pc_load`=1 and `opcode`=`instr_opcode` for exactly one cycle. Next state ISSUE_OP.
- Address arithmetic is modulo 2^ADDR_W; with ADDR_W=6, 63+1=0.
- `pc` is sampled combinationally in every issue state. `pc` must not change except on `pc_load`.
- Bundle outputs hold stable while in DELIVER.
- Operand registers clear to 0 at every WAIT_OP, so unused operands read 0.
- `flush`=1 in any state forces ISSUE_OP on the next cycle and drops `instr_valid`. A `pc_load` already showing in ADVANCE still completes that cycle; no new `pc_load` is raised.
- `flush` and `instr_ready` in the same DELIVER cycle: `flush` wins, and no `pc_load` follows.

## Timing
- Reset (`reset`=0): state ISSUE_OP, and all outputs are 0. This includes `mem_rd`, which is gated 0 while in reset, as well as `mem_addr`, `instr_*`, `pc_load`, `opcode` and `halted`.
- First `mem_rd` appears in the first cycle after `reset` rises.
- Cycles from ISSUE_OP to `instr_valid`: 2 for 0 operands, 3 for 1 operand, 4 for 2 operands.
- Cycles per instruction with `instr_ready` tied to 1: 4, 5 or 6 respectively.
- `program_counter` updates on the edge ending ADVANCE, so the new `pc` is visible in the following ISSUE_OP.
- Asynchronous reset mid-fetch aborts immediately. No `pc_load` is emitted.

## Configuration
- `IFETCH_HALT_EN` defined:
  - Opcode 0xF4 decodes as 0 operands.
  - After 0xF4 is accepted in DELIVER, the FSM enters HALTED instead of ADVANCE. No `pc_load` is issued.
  - In HALTED, `halted`=1 and `mem_rd`=0.
  - HALTED exits only on `reset` or `flush` (to ISSUE_OP).
- Not defined: 0xF4 is an ordinary 2-operand opcode, and `halted` is constant 0.

## Test plan
Bench models `program_counter` as `pc += 1+nops` on `pc_load`. ROM contents:
- [0]=0x83
- [1]=0x78, [2]=0x11
- [3]=0xFF, [4]=0x22, [5]=0x33
- [62]=0xFF, [63]=0xAA, [0]=0x83

Scenarios:
- Reset held 3 cycles → every output 0; first `mem_rd` with `mem_addr`=0 in the cycle after release.
- `pc`=0 (0x83) → `instr_valid` 2 cycles after ISSUE_OP with nops=0 and opnd_a=opnd_b=0; then a one-cycle `pc_load` with `opcode`=0x83; `pc` becomes 1.
- `pc`=1 (0x78) → `mem_addr` sequence 1,2; bundle {0x78, nops=1, opnd_a=0x11, opnd_b=0}; `pc` becomes 3.
- `pc`=3 (0xFF) → `mem_addr` sequence 3,4,5; bundle {0xFF, 2, 0x22, 0x33}; `pc` becomes 6.
- Backpressure: `instr_ready`=0 for 5 cycles in DELIVER → bundle stable and no `pc_load`; `instr_ready`=1 → exactly one `pc_load`.
- Wrap and flush:
  - `pc`=62 → `mem_addr` sequence 62,63,0.
  - Repeat with `flush` in WAIT_A → next cycle `mem_rd` at `mem_addr`=62; no `pc_load`.
  - With `IFETCH_HALT_EN`, opcode 0xF4 → `halted`=1 and `mem_rd` stays 0 until `flush`.
